// File: rtl/burst_detect.sv
// burst_detect
//   Qualifies a modulated burst on an already-synchronised input. A burst is
//   a train of alternating high/low phases, each CLKS_PER_HALF_PERIOD +/-
//   TOLERANCE samples wide, terminated by a low run of H+T+1 samples. A
//   well-formed burst with MIN_PULSES..MAX_PULSES high phases yields a
//   one-cycle detect strobe; anything else yields a one-cycle error strobe
//   with a cause code.
//
// Ports
//   clk       system clock, all logic on posedge
//   n_reset   synchronous active-low reset
//   in        synchronised modulated input
//   detect    one-cycle strobe: valid burst ended
//   error     one-cycle strobe: malformed burst
//   err_code  cause of last error: 0 none, 1 short phase, 2 long high,
//             3 pulse count out of range
//   count     high phases seen in the last burst (valid or not)
//   busy      high while a burst is being tracked (HIGH or LOW state)
module burst_detect #(
  parameter int CLKS_PER_HALF_PERIOD = 3,
  parameter int TOLERANCE            = 1,
  parameter int MIN_PULSES           = 10,
  parameter int MAX_PULSES           = 12,
  parameter int COUNT_WIDTH          = 8
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   in,
  output logic                   detect,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy
);

  localparam int RUN_MIN = CLKS_PER_HALF_PERIOD - TOLERANCE;
  localparam int RUN_LIM = CLKS_PER_HALF_PERIOD + TOLERANCE + 1;
  localparam int RUN_W   = $clog2(RUN_LIM + 1);

  localparam logic [RUN_W-1:0]       RUN_MIN_C = RUN_W'(RUN_MIN);
  localparam logic [RUN_W-1:0]       RUN_LIM_C = RUN_W'(RUN_LIM);
  localparam logic [COUNT_WIDTH-1:0] P_MIN_C   = COUNT_WIDTH'(MIN_PULSES);
  localparam logic [COUNT_WIDTH-1:0] P_MAX_C   = COUNT_WIDTH'(MAX_PULSES);

  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;
  localparam logic [1:0] ERR_COUNT = 2'd3;

  typedef enum logic [1:0] {
    RECOVER = 2'd0,
    IDLE    = 2'd1,
    HIGH    = 2'd2,
    LOW     = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [RUN_W-1:0]       w, w_nxt;
  logic [RUN_W-1:0]       gap, gap_nxt;
  logic [COUNT_WIDTH-1:0] p, p_nxt;
  logic                   detect_nxt, error_nxt;
  logic [1:0]             err_code_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt;
  logic [RUN_W-1:0]       w_inc, gap_inc;

  // Run counters stop at the limit value; the FSM leaves the state there
  // anyway, so saturation only guards against wrap.
  function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] v);
    return (v >= RUN_LIM_C) ? RUN_LIM_C : v + 1'b1;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_cnt(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_inc   = sat_run(w);
  assign gap_inc = sat_run(gap);
  assign busy    = (state == HIGH) || (state == LOW);

  always_comb begin
    state_nxt    = state;
    w_nxt        = w;
    gap_nxt      = gap;
    p_nxt        = p;
    detect_nxt   = 1'b0;
    error_nxt    = 1'b0;
    err_code_nxt = err_code;
    count_nxt    = count;

    unique case (state)
      RECOVER: begin
        // Need a clean low gap before trusting the next rising edge.
        if (in) begin
          gap_nxt = '0;
        end else if (gap_inc == RUN_LIM_C) begin
          gap_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_inc;
        end
      end

      IDLE: begin
        if (in) begin
          state_nxt = HIGH;
          w_nxt     = RUN_W'(1);
          p_nxt     = '0;
        end
      end

      HIGH: begin
        if (in) begin
          if (w_inc == RUN_LIM_C) begin
            error_nxt    = 1'b1;
            err_code_nxt = ERR_LONG;
            count_nxt    = p;
            gap_nxt      = '0;
            state_nxt    = RECOVER;
          end else begin
            w_nxt = w_inc;
          end
        end else if (w < RUN_MIN_C) begin
          error_nxt    = 1'b1;
          err_code_nxt = ERR_SHORT;
          count_nxt    = p;
          gap_nxt      = '0;
          state_nxt    = RECOVER;
        end else begin
          // A high phase is counted once it closes with a valid width.
          p_nxt     = sat_cnt(p);
          w_nxt     = RUN_W'(1);
          state_nxt = LOW;
        end
      end

      LOW: begin
        if (in) begin
          if (w < RUN_MIN_C) begin
            error_nxt    = 1'b1;
            err_code_nxt = ERR_SHORT;
            count_nxt    = p;
            gap_nxt      = '0;
            state_nxt    = RECOVER;
          end else begin
            w_nxt     = RUN_W'(1);
            state_nxt = HIGH;
          end
        end else if (w_inc == RUN_LIM_C) begin
          // Over-long low run terminates the burst and already counts as
          // the idle gap, so go straight to IDLE.
          count_nxt = p;
          if ((p >= P_MIN_C) && (p <= P_MAX_C)) begin
            detect_nxt   = 1'b1;
            err_code_nxt = 2'd0;
          end else begin
            error_nxt    = 1'b1;
            err_code_nxt = ERR_COUNT;
          end
          state_nxt = IDLE;
        end else begin
          w_nxt = w_inc;
        end
      end

      default: state_nxt = RECOVER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= RECOVER;
      w        <= '0;
      gap      <= '0;
      p        <= '0;
      detect   <= 1'b0;
      error    <= 1'b0;
      err_code <= 2'd0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      w        <= w_nxt;
      gap      <= gap_nxt;
      p        <= p_nxt;
      detect   <= detect_nxt;
      error    <= error_nxt;
      err_code <= err_code_nxt;
      count    <= count_nxt;
    end
  end

endmodule

// File: tb/tb_burst_detect.sv
// tb_burst_detect
//   Directed bench for burst_detect with default parameters (H=3, T=1,
//   10..12 pulses). Stimulus pushes the expected strobe (kind, code, count,
//   cycle) into a queue at the deciding sample; a negedge monitor pops and
//   compares whenever detect or error is high.
module tb_burst_detect;

  logic       clk;
  logic       n_reset;
  logic       in;
  logic       detect;
  logic       error;
  logic [1:0] err_code;
  logic [7:0] count;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit is_err;
    int code;
    int cnt;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;

  burst_detect #(
    .CLKS_PER_HALF_PERIOD(3),
    .TOLERANCE(1),
    .MIN_PULSES(10),
    .MAX_PULSES(12),
    .COUNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .in(in),
    .detect(detect),
    .error(error),
    .err_code(err_code),
    .count(count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One input sample: drive, let the DUT sample it, settle 1 time unit.
  task automatic drive(input logic v);
    in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic lows(input int n);
    for (int i = 0; i < n; i++) drive(1'b0);
  endtask

  task automatic highs(input int n);
    for (int i = 0; i < n; i++) drive(1'b1);
  endtask

  // n pulses of hi/lo; the final high phase is left open (no trailing low).
  task automatic burst(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      highs(hi);
      if (i < n - 1) lows(lo);
    end
  endtask

  // Called right after the deciding sample has been taken.
  task automatic expect_ev(input bit is_err, input int code, input int cnt);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.cnt    = cnt;
    e.cyc    = cyc;
    q.push_back(e);
  endtask

  // Terminating gap: the 5th low sample decides the burst.
  task automatic gap_end(input bit is_err, input int code, input int cnt);
    lows(4);
    drive(1'b0);
    expect_ev(is_err, code, cnt);
  endtask

  always @(negedge clk) begin
    if (detect || error) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe detect=%0d error=%0d err_code=%0d count=%0d required=none (cycle %0d)",
                 detect, error, err_code, count, cyc);
      end else begin
        e_mon = q.pop_front();
        chk("strobe_detect", int'(detect), e_mon.is_err ? 0 : 1);
        chk("strobe_error", int'(error), e_mon.is_err ? 1 : 0);
        chk("strobe_err_code", int'(err_code), e_mon.code);
        chk("strobe_count", int'(count), e_mon.cnt);
        chk("strobe_cycle", cyc, e_mon.cyc);
      end
    end
  end

  initial begin
    n_reset = 1'b0;
    in      = 1'b0;
    drive(1'b0);
    drive(1'b0);
    n_reset = 1'b1;
    chk("reset_detect", int'(detect), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_err_code", int'(err_code), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_busy", int'(busy), 0);
    lows(10);

    // 12 nominal pulses -> detect 5 cycles after last fall
    drive(1'b1);
    chk("busy_after_first_high", int'(busy), 1);
    highs(2);
    lows(3);
    burst(11, 3, 3);
    gap_end(1'b0, 0, 12);
    chk("detect_direct", int'(detect), 1);
    chk("busy_low_with_detect", int'(busy), 0);

    // 8 pulses -> count error, then back-to-back valid burst
    burst(8, 3, 3);
    gap_end(1'b1, 3, 8);
    burst(12, 3, 3);
    gap_end(1'b0, 0, 12);

    // tolerance edges: widths alternating 2 and 4
    for (int i = 0; i < 12; i++) begin
      highs((i % 2) ? 4 : 2);
      if (i < 11) lows((i % 2) ? 2 : 4);
    end
    gap_end(1'b0, 0, 12);

    // 4th high phase 5 wide -> long-high error after its 5th sample
    burst(3, 3, 3);
    lows(3);
    highs(4);
    drive(1'b1);
    expect_ev(1'b1, 2, 3);
    lows(5);

    // single-cycle glitch in IDLE -> short-phase error, count 0
    drive(1'b1);
    drive(1'b0);
    expect_ev(1'b1, 1, 0);
    lows(5);
    burst(12, 3, 3);
    gap_end(1'b0, 0, 12);

    // 13 pulses -> count error
    burst(13, 3, 3);
    gap_end(1'b1, 3, 13);

    // 1-cycle low notch after 5th high phase -> short-phase error, count 5
    burst(4, 3, 3);
    lows(3);
    highs(3);
    drive(1'b0);
    drive(1'b1);
    expect_ev(1'b1, 1, 5);
    lows(5);

    // reset mid-burst: silent abort, then recovery gap and fresh burst
    burst(3, 3, 3);
    lows(3);
    drive(1'b1);
    chk("busy_before_reset", int'(busy), 1);
    n_reset = 1'b0;
    drive(1'b1);
    n_reset = 1'b1;
    chk("midreset_detect", int'(detect), 0);
    chk("midreset_error", int'(error), 0);
    chk("midreset_err_code", int'(err_code), 0);
    chk("midreset_count", int'(count), 0);
    chk("midreset_busy", int'(busy), 0);
    highs(1);
    lows(3);
    burst(3, 3, 3);
    lows(5);
    burst(12, 3, 3);
    gap_end(1'b0, 0, 12);
    chk("count_holds", int'(count), 12);

    lows(10);
    chk("pending_expectations", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
